// File: rtl/road_edge_if.sv
`default_nettype none
// ============================================================================
//  Module   : road_edge_if
//  Purpose  : Control and read-port bundle of the road-edge table.
//             master = game logic / renderer side, slave = road_edge_generator.
//  Signals  : tick, restart      game-tick scroll pulse, re-initialise pulse
//             ready              table valid, ticks accepted
//             rd_row/rd_*        renderer read port (1-cycle latency)
//             probe_row/probe_*  collision probe read port (1-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
interface road_edge_if;
    logic       tick;
    logic       restart;
    logic       ready;
    logic [8:0] rd_row;
    logic [9:0] rd_left;
    logic [9:0] rd_right;
    logic [8:0] probe_row;
    logic [9:0] probe_left;
    logic [9:0] probe_right;

    modport master (
        output tick, restart, rd_row, probe_row,
        input  ready, rd_left, rd_right, probe_left, probe_right
    );

    modport slave (
        input  tick, restart, rd_row, probe_row,
        output ready, rd_left, rd_right, probe_left, probe_right
    );
endinterface
`default_nettype wire

// File: rtl/road_edge_generator.sv
`default_nettype none
// ============================================================================
//  Module   : road_edge_generator
//  Purpose  : Writer side of the road-edge table. Keeps one road centre per
//             visible row in a ROWS-deep ring buffer, scrolls it down one row
//             per game tick and generates each new top row from an
//             LFSR-selected curvature, clamped to the legal screen span.
//             Two independent registered read ports return left/right edges.
//  Ports    : clk  - game clock
//             rst  - asynchronous, active-high reset
//             bus  - road_edge_if.slave (tick/restart/ready + two read ports)
//  Revision : 1.0  initial release
// ============================================================================
module road_edge_generator #(
    parameter int          ROWS       = 480,
    parameter int          XCENTER    = 464,
    parameter int          HALF_WIDTH = 50,
    parameter int          X_MIN      = 152,
    parameter int          X_MAX      = 775,
    parameter int          STEP       = 2,
    parameter int          HOLD_TICKS = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    road_edge_if.slave   bus
);

    localparam int c_aw     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_hold_w = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [8:0]          c_last_row  = 9'(ROWS - 1);
    localparam logic [9:0]          c_rows      = 10'(ROWS);
    localparam logic [9:0]          c_xc        = 10'(XCENTER);
    localparam logic [9:0]          c_hw        = 10'(HALF_WIDTH);
    localparam logic [9:0]          c_left_dflt = 10'(XCENTER - HALF_WIDTH);
    localparam logic [9:0]          c_right_dflt= 10'(XCENTER + HALF_WIDTH);
    localparam logic signed [11:0]  c_lo        = 12'(X_MIN + HALF_WIDTH);
    localparam logic signed [11:0]  c_hi        = 12'(X_MAX - HALF_WIDTH);
    localparam logic signed [11:0]  c_step      = 12'(STEP);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_TICKS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                 r_state,   w_state_nxt;
    logic [8:0]             r_clr_ptr, w_clr_ptr_nxt;
    logic [8:0]             r_head,    w_head_nxt;
    logic [9:0]             r_centre,  w_centre_nxt;
    logic signed [11:0]     r_delta,   w_delta_nxt;
    logic [c_hold_w-1:0]    r_hold,    w_hold_nxt;
    logic [15:0]            r_lfsr,    w_lfsr_nxt;

    logic                   w_we;
    logic [c_aw-1:0]        w_waddr;
    logic [9:0]             w_wdata;

    logic [9:0]             r_mem [ROWS];

    // ------------------------------------------------------------------
    // Next-centre arithmetic, done wide and signed so a step past either
    // screen edge is detected rather than wrapping.
    // ------------------------------------------------------------------
    logic signed [11:0] w_sum;
    logic               w_clamp_lo;
    logic               w_clamp_hi;
    logic [9:0]         w_nc;
    logic               w_lfsr_fb;

    assign w_sum      = $signed({2'b00, r_centre}) + r_delta;
    assign w_clamp_lo = (w_sum < c_lo);
    assign w_clamp_hi = (w_sum > c_hi);
    assign w_nc       = w_clamp_lo ? c_lo[9:0] : (w_clamp_hi ? c_hi[9:0] : w_sum[9:0]);
    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Logical row -> physical RAM index relative to the current head.
    function automatic logic [c_aw-1:0] f_phys(input logic [8:0] head, input logic [8:0] row);
        logic [9:0] s;
        s = {1'b0, head} + {1'b0, row};
        if (s >= c_rows)
            s = s - c_rows;
        return s[c_aw-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_head    <= '0;
            r_centre  <= c_xc;
            r_delta   <= '0;
            r_hold    <= '0;
            r_lfsr    <= LFSR_SEED;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_head    <= w_head_nxt;
            r_centre  <= w_centre_nxt;
            r_delta   <= w_delta_nxt;
            r_hold    <= w_hold_nxt;
            r_lfsr    <= w_lfsr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / write-port logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_head_nxt    = r_head;
        w_centre_nxt  = r_centre;
        w_delta_nxt   = r_delta;
        w_hold_nxt    = r_hold;
        w_lfsr_nxt    = r_lfsr;
        w_we          = 1'b0;
        w_waddr       = '0;
        w_wdata       = '0;

        if (bus.restart) begin
            // Restart takes priority over any tick; the LFSR is left running
            // so each life gets a different road.
            w_state_nxt   = ST_CLEAR;
            w_clr_ptr_nxt = '0;
            w_head_nxt    = '0;
            w_centre_nxt  = c_xc;
            w_delta_nxt   = '0;
            w_hold_nxt    = '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    w_we    = 1'b1;
                    w_waddr = r_clr_ptr[c_aw-1:0];
                    w_wdata = c_xc;
                    if (r_clr_ptr == c_last_row) begin
                        w_state_nxt   = ST_RUN;
                        w_clr_ptr_nxt = '0;
                    end else begin
                        w_clr_ptr_nxt = r_clr_ptr + 9'd1;
                    end
                end
                ST_RUN: begin
                    if (bus.tick) begin
                        w_head_nxt   = (r_head == 9'd0) ? c_last_row : r_head - 9'd1;
                        w_we         = 1'b1;
                        w_waddr      = w_head_nxt[c_aw-1:0];
                        w_wdata      = w_nc;
                        w_centre_nxt = w_nc;
                        w_lfsr_nxt   = {r_lfsr[14:0], w_lfsr_fb};

                        if (r_hold == c_hold_last) begin
                            w_hold_nxt = '0;
                            case (r_lfsr[1:0])
                                2'b01:   w_delta_nxt = c_step;
                                2'b10:   w_delta_nxt = -c_step;
                                default: w_delta_nxt = '0;
                            endcase
                        end else begin
                            w_hold_nxt = r_hold + 1'b1;
                        end

                        // Bouncing off an edge overrides a fresh re-selection.
                        if (w_clamp_lo)
                            w_delta_nxt = c_step;
                        else if (w_clamp_hi)
                            w_delta_nxt = -c_step;
                    end
                end
                default: w_state_nxt = ST_CLEAR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Centre RAM: one write port, two registered read ports.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    logic [c_aw-1:0] w_rd_phys;
    logic [c_aw-1:0] w_pr_phys;
    logic            w_rd_oob;
    logic            w_pr_oob;
    logic [9:0]      w_rd_c;
    logic [9:0]      w_pr_c;

    assign w_rd_phys = f_phys(r_head, bus.rd_row);
    assign w_pr_phys = f_phys(r_head, bus.probe_row);
    assign w_rd_oob  = ({1'b0, bus.rd_row}    >= c_rows);
    assign w_pr_oob  = ({1'b0, bus.probe_row} >= c_rows);
    assign w_rd_c    = r_mem[w_rd_phys];
    assign w_pr_c    = r_mem[w_pr_phys];

    // Until the table is valid both ports report the straight-road edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_left     <= '0;
            bus.rd_right    <= '0;
            bus.probe_left  <= '0;
            bus.probe_right <= '0;
        end else begin
            if (w_rd_oob) begin
                bus.rd_left  <= '0;
                bus.rd_right <= '0;
            end else if (r_state != ST_RUN) begin
                bus.rd_left  <= c_left_dflt;
                bus.rd_right <= c_right_dflt;
            end else begin
                bus.rd_left  <= w_rd_c - c_hw;
                bus.rd_right <= w_rd_c + c_hw;
            end

            if (w_pr_oob) begin
                bus.probe_left  <= '0;
                bus.probe_right <= '0;
            end else if (r_state != ST_RUN) begin
                bus.probe_left  <= c_left_dflt;
                bus.probe_right <= c_right_dflt;
            end else begin
                bus.probe_left  <= w_pr_c - c_hw;
                bus.probe_right <= w_pr_c + c_hw;
            end
        end
    end

    assign bus.ready = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_road_edge_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_road_edge_generator
//  Purpose  : Self-checking bench for road_edge_generator. A default-sized
//             instance covers clear, scroll, wrap, restart and reset cases;
//             a narrow-corridor instance makes the edge clamp occur quickly.
//             Expected centres come from a behavioural road model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_road_edge_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    road_edge_if bus   ();
    road_edge_if bus_s ();

    road_edge_generator u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    road_edge_generator #(
        .ROWS       (16),
        .HALF_WIDTH (300),
        .HOLD_TICKS (4)
    ) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Road model
    bit          use_s;
    int          cfg_rows, cfg_xc, cfg_hw, cfg_hold;
    int          m_row [480];
    int          m_centre, m_delta, m_hold;
    logic [15:0] m_lfsr;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input bit keep_lfsr);
        m_centre = cfg_xc;
        m_delta  = 0;
        m_hold   = 0;
        if (!keep_lfsr)
            m_lfsr = 16'hACE1;
        for (int r = 0; r < 480; r++)
            m_row[r] = cfg_xc;
    endtask

    task automatic model_tick();
        int   nc;
        logic fb;
        nc = m_centre + m_delta;
        if (m_hold == cfg_hold - 1) begin
            m_hold = 0;
            if (m_lfsr[1:0] == 2'b01)      m_delta = 2;
            else if (m_lfsr[1:0] == 2'b10) m_delta = -2;
            else                           m_delta = 0;
        end else begin
            m_hold++;
        end
        if (nc - cfg_hw < 152) begin
            nc = 152 + cfg_hw;
            m_delta = 2;
        end else if (nc + cfg_hw > 775) begin
            nc = 775 - cfg_hw;
            m_delta = -2;
        end
        fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr = {m_lfsr[14:0], fb};
        for (int r = cfg_rows - 1; r > 0; r--)
            m_row[r] = m_row[r-1];
        m_row[0] = nc;
        m_centre = nc;
    endtask

    task automatic set_rows(input int r, input int p);
        bus.rd_row      = 9'(r);
        bus.probe_row   = 9'(p);
        bus_s.rd_row    = 9'(r);
        bus_s.probe_row = 9'(p);
    endtask

    task automatic drive(input bit t, input bit rs);
        if (use_s) begin
            bus_s.tick = t; bus_s.restart = rs;
        end else begin
            bus.tick = t;   bus.restart = rs;
        end
    endtask

    task automatic do_tick();
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0);
        model_tick();
    endtask

    task automatic check_ready(input string tag, input int exp);
        check_val(tag, use_s ? int'(bus_s.ready) : int'(bus.ready), exp);
    endtask

    task automatic check_outs(input string tag, input int el, input int er,
                              input int epl, input int epr);
        int ol, orr, opl, opr;
        ol  = use_s ? int'(bus_s.rd_left)     : int'(bus.rd_left);
        orr = use_s ? int'(bus_s.rd_right)    : int'(bus.rd_right);
        opl = use_s ? int'(bus_s.probe_left)  : int'(bus.probe_left);
        opr = use_s ? int'(bus_s.probe_right) : int'(bus.probe_right);
        check_val({tag, "_rd_left"},     ol,  el);
        check_val({tag, "_rd_right"},    orr, er);
        check_val({tag, "_probe_left"},  opl, epl);
        check_val({tag, "_probe_right"}, opr, epr);
    endtask

    // Read every row on both ports (probe walks bottom-up) against the model.
    task automatic sweep(input string tag);
        for (int r = 0; r < cfg_rows; r++) begin
            set_rows(r, cfg_rows - 1 - r);
            step();
            check_outs($sformatf("%s[%0d]", tag, r),
                       m_row[r] - cfg_hw, m_row[r] + cfg_hw,
                       m_row[cfg_rows-1-r] - cfg_hw, m_row[cfg_rows-1-r] + cfg_hw);
        end
    endtask

    // Called right after the edge that starts CLEAR; CLEAR then spans ROWS edges.
    task automatic wait_clear(input string tag, input int done);
        repeat (cfg_rows - done - 1) step();
        check_ready({tag, "_ready_low"}, 0);
        step();
        check_ready({tag, "_ready_high"}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        use_s = 1'b0;
        cfg_rows = 480; cfg_xc = 464; cfg_hw = 50; cfg_hold = 16;
        bus.tick = 0;   bus.restart = 0;
        bus_s.tick = 0; bus_s.restart = 0;
        set_rows(0, 0);

        // ---- 1: reset state, CLEAR duration, straight road ----
        step(); step();
        check_ready("rst_ready", 0);
        check_outs("rst", 0, 0, 0, 0);
        model_reset(1'b0);
        rst = 1'b0;
        step();
        check_ready("clr_ready", 0);
        check_outs("clr_dflt", 414, 514, 414, 514);
        wait_clear("t1", 1);
        sweep("t1");

        // ---- 2: short scroll ----
        repeat (5) do_tick();
        sweep("t2");

        // ---- 4: full head wrap ----
        repeat (480) do_tick();
        sweep("t4");

        // ---- 6a: out-of-range rows ----
        set_rows(480, 511);
        step();
        check_outs("oob", 0, 0, 0, 0);

        // ---- 5: restart with simultaneous tick, LFSR kept ----
        drive(1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0);
        model_reset(1'b1);
        check_ready("t5_ready_now", 0);
        wait_clear("t5", 0);
        sweep("t5_clear");
        repeat (40) do_tick();
        sweep("t5_lfsr");

        // ---- 6b: tick during CLEAR is ignored ----
        drive(1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0);
        model_reset(1'b1);
        repeat (10) step();
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0);
        wait_clear("t6_tick", 11);
        sweep("t6_tick");
        repeat (40) do_tick();
        sweep("t6_tick_run");

        // ---- 6c: asynchronous reset mid-CLEAR ----
        drive(1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0);
        set_rows(3, 7);
        repeat (100) step();
        check_outs("mid_clr", 414, 514, 414, 514);
        #1;
        rst = 1'b1;
        #1;
        check_ready("arst_ready", 0);
        check_outs("arst", 0, 0, 0, 0);
        step();
        rst = 1'b0;
        model_reset(1'b0);
        wait_clear("arst", 0);
        sweep("arst_clear");
        repeat (40) do_tick();
        sweep("arst_run");

        // ---- 3: clamp/bounce in a narrow corridor (centre 452..475) ----
        use_s = 1'b1;
        cfg_rows = 16; cfg_xc = 464; cfg_hw = 300; cfg_hold = 4;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset(1'b0);
        wait_clear("s", 0);
        sweep("s_clear");
        for (int blk = 0; blk < 12; blk++) begin
            repeat (16) do_tick();
            sweep($sformatf("s_blk%0d", blk));
        end
        set_rows(16, 300);
        step();
        check_outs("s_oob", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
